// File: rtl/riscv_pkg.sv
// Shared definitions for the memory-port arbiter: FSM state encoding and
// requester (owner) identifiers, also used to index per-requester vectors.
package riscv_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        BUSY_IF = 2'd1,
        BUSY_DM = 2'd2
    } arb_state_e;

    localparam logic OWN_IF = 1'b0;
    localparam logic OWN_DM = 1'b1;

endpackage

// File: rtl/arb_pick.sv
// Combinational winner selection between Fetch and Memory-stage requests.
// Build option ARB_RR_EN: alternate on contention instead of fixed dm priority.
module arb_pick
    import riscv_pkg::*;
(
    input  logic       if_req,
    input  logic       dm_req,
    input  logic       last_owner,
    output logic [1:0] win_onehot
);

`ifdef ARB_RR_EN
    logic dm_wins_tie;

    // On contention the requester that did not own the port last goes first.
    assign dm_wins_tie = (last_owner == OWN_IF);
`else
    logic dm_wins_tie;
    logic unused_last_owner;

    assign dm_wins_tie       = 1'b1;
    assign unused_last_owner = last_owner;
`endif

    always_comb begin
        win_onehot = 2'b00;
        if (if_req && dm_req) begin
            if (dm_wins_tie) begin
                win_onehot[OWN_DM] = 1'b1;
            end else begin
                win_onehot[OWN_IF] = 1'b1;
            end
        end else if (dm_req) begin
            win_onehot[OWN_DM] = 1'b1;
        end else if (if_req) begin
            win_onehot[OWN_IF] = 1'b1;
        end
    end

endmodule

// File: rtl/mem_port_arbiter.sv
// Serialises Fetch reads and Memory-stage loads/stores onto one memory port.
// Build option ARB_RR_EN enables alternating priority on simultaneous requests.
module mem_port_arbiter
    import riscv_pkg::*;
#(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                if_req,
    input  logic [ADDR_W-1:0]   if_addr,
    output logic                if_gnt,
    output logic                if_rvalid,
    output logic [DATA_W-1:0]   if_rdata,
    input  logic                dm_req,
    input  logic                dm_we,
    input  logic [ADDR_W-1:0]   dm_addr,
    input  logic [DATA_W-1:0]   dm_wdata,
    input  logic [DATA_W/8-1:0] dm_be,
    output logic                dm_gnt,
    output logic                dm_rvalid,
    output logic [DATA_W-1:0]   dm_rdata,
    output logic                mem_req,
    output logic                mem_we,
    output logic [ADDR_W-1:0]   mem_addr,
    output logic [DATA_W-1:0]   mem_wdata,
    output logic [DATA_W/8-1:0] mem_be,
    input  logic                mem_ack,
    input  logic [DATA_W-1:0]   mem_rdata,
    output logic                stall_if,
    output logic                stall_mem
);

    localparam int BE_W = DATA_W / 8;

    arb_state_e          state_reg;
    arb_state_e          state_next;
    logic [1:0]          win_onehot;
    logic                last_owner;
    logic [1:0]          done_vec;
    logic                mem_req_reg;
    logic                mem_we_reg;
    logic [ADDR_W-1:0]   mem_addr_reg;
    logic [DATA_W-1:0]   mem_wdata_reg;
    logic [BE_W-1:0]     mem_be_reg;
    logic [DATA_W-1:0]   rdata_reg [2];
    logic                rvalid_reg [2];

`ifdef ARB_RR_EN
    logic last_owner_reg;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            last_owner_reg <= OWN_IF;
        end else if (dm_gnt) begin
            last_owner_reg <= OWN_DM;
        end else if (if_gnt) begin
            last_owner_reg <= OWN_IF;
        end
    end

    assign last_owner = last_owner_reg;
`else
    assign last_owner = OWN_IF;
`endif

    arb_pick u_arb_pick (
        .if_req     (if_req),
        .dm_req     (dm_req),
        .last_owner (last_owner),
        .win_onehot (win_onehot)
    );

    // Grants come only from the state and the requests, never from mem_ack.
    always_comb begin
        state_next = state_reg;
        if_gnt     = 1'b0;
        dm_gnt     = 1'b0;
        case (state_reg)
            IDLE: begin
                if (win_onehot[OWN_DM]) begin
                    dm_gnt     = 1'b1;
                    state_next = BUSY_DM;
                end else if (win_onehot[OWN_IF]) begin
                    if_gnt     = 1'b1;
                    state_next = BUSY_IF;
                end
            end
            BUSY_IF, BUSY_DM: begin
                if (mem_ack) begin
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg <= IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    // Memory request fields only change on a grant edge so they stay stable while busy.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mem_req_reg   <= 1'b0;
            mem_we_reg    <= 1'b0;
            mem_addr_reg  <= '0;
            mem_wdata_reg <= '0;
            mem_be_reg    <= '0;
        end else if (dm_gnt) begin
            mem_req_reg   <= 1'b1;
            mem_we_reg    <= dm_we;
            mem_addr_reg  <= dm_addr;
            mem_wdata_reg <= dm_wdata;
            mem_be_reg    <= dm_be;
        end else if (if_gnt) begin
            mem_req_reg   <= 1'b1;
            mem_we_reg    <= 1'b0;
            mem_addr_reg  <= if_addr;
            mem_wdata_reg <= '0;
            mem_be_reg    <= '1;
        end else if (done_vec != 2'b00) begin
            mem_req_reg   <= 1'b0;
        end
    end

    assign done_vec[OWN_IF] = mem_ack && (state_reg == BUSY_IF);
    assign done_vec[OWN_DM] = mem_ack && (state_reg == BUSY_DM);

    // Per-requester return path; a store completes with zero data.
    generate
        for (genvar gi = 0; gi < 2; gi++) begin : g_ret
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    rdata_reg[gi]  <= '0;
                    rvalid_reg[gi] <= 1'b0;
                end else begin
                    rvalid_reg[gi] <= done_vec[gi];
                    if (done_vec[gi]) begin
                        rdata_reg[gi] <= mem_we_reg ? '0 : mem_rdata;
                    end
                end
            end
        end
    endgenerate

    assign if_rvalid = rvalid_reg[OWN_IF];
    assign if_rdata  = rdata_reg[OWN_IF];
    assign dm_rvalid = rvalid_reg[OWN_DM];
    assign dm_rdata  = rdata_reg[OWN_DM];

    assign mem_req   = mem_req_reg;
    assign mem_we    = mem_we_reg;
    assign mem_addr  = mem_addr_reg;
    assign mem_wdata = mem_wdata_reg;
    assign mem_be    = mem_be_reg;

    assign stall_if  = (if_req && !if_gnt) || (state_reg == BUSY_IF);
    assign stall_mem = (dm_req && !dm_gnt) || (state_reg == BUSY_DM);

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed self-checking bench for mem_port_arbiter; inputs change 1 ns after
// the rising edge and outputs are sampled on the falling edge.
module tb_mem_port_arbiter;

    localparam int ADDR_W = 32;
    localparam int DATA_W = 32;

    logic                clk;
    logic                rst_n;
    logic                if_req;
    logic [ADDR_W-1:0]   if_addr;
    logic                if_gnt;
    logic                if_rvalid;
    logic [DATA_W-1:0]   if_rdata;
    logic                dm_req;
    logic                dm_we;
    logic [ADDR_W-1:0]   dm_addr;
    logic [DATA_W-1:0]   dm_wdata;
    logic [DATA_W/8-1:0] dm_be;
    logic                dm_gnt;
    logic                dm_rvalid;
    logic [DATA_W-1:0]   dm_rdata;
    logic                mem_req;
    logic                mem_we;
    logic [ADDR_W-1:0]   mem_addr;
    logic [DATA_W-1:0]   mem_wdata;
    logic [DATA_W/8-1:0] mem_be;
    logic                mem_ack;
    logic [DATA_W-1:0]   mem_rdata;
    logic                stall_if;
    logic                stall_mem;

    int n_checks = 0;
    int n_fail   = 0;

    mem_port_arbiter #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .if_req    (if_req),
        .if_addr   (if_addr),
        .if_gnt    (if_gnt),
        .if_rvalid (if_rvalid),
        .if_rdata  (if_rdata),
        .dm_req    (dm_req),
        .dm_we     (dm_we),
        .dm_addr   (dm_addr),
        .dm_wdata  (dm_wdata),
        .dm_be     (dm_be),
        .dm_gnt    (dm_gnt),
        .dm_rvalid (dm_rvalid),
        .dm_rdata  (dm_rdata),
        .mem_req   (mem_req),
        .mem_we    (mem_we),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .mem_be    (mem_be),
        .mem_ack   (mem_ack),
        .mem_rdata (mem_rdata),
        .stall_if  (stall_if),
        .stall_mem (stall_mem)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    always @(negedge clk) begin
        if (if_rvalid) $display("txn if  rdata=%h", if_rdata);
        if (dm_rvalid) $display("txn dm  rdata=%h", dm_rdata);
    end

    task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp_v);
        n_checks++;
        if (obs !== exp_v) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp_v);
        end
    endtask

    task automatic step;
        @(posedge clk);
        #1;
    endtask

    task automatic sample;
        @(negedge clk);
    endtask

    logic fdm;
    logic exp_dm;

    initial begin
        rst_n = 1'b0;
        if_req = 1'b0; if_addr = '0;
        dm_req = 1'b0; dm_we = 1'b0; dm_addr = '0; dm_wdata = '0; dm_be = '0;
        mem_ack = 1'b0; mem_rdata = '0;

        // Reset state
        sample;
        check_eq("rst_mem_req", mem_req, 0);
        check_eq("rst_mem_addr", mem_addr, 0);
        check_eq("rst_if_rvalid", if_rvalid, 0);
        check_eq("rst_if_rdata", if_rdata, 0);
        check_eq("rst_dm_rdata", dm_rdata, 0);
        check_eq("rst_stall_if", stall_if, 0);
        check_eq("rst_stall_mem", stall_mem, 0);
        step;
        rst_n = 1'b1;

        // Single fetch, zero wait
        step;
        if_req = 1'b1; if_addr = 32'h100;
        sample;
        check_eq("t1_if_gnt", if_gnt, 1);
        check_eq("t1_dm_gnt", dm_gnt, 0);
        step;
        if_req = 1'b0; if_addr = '0; mem_ack = 1'b1; mem_rdata = 32'h0050_0093;
        sample;
        check_eq("t1_mem_req", mem_req, 1);
        check_eq("t1_mem_addr", mem_addr, 32'h100);
        check_eq("t1_mem_we", mem_we, 0);
        check_eq("t1_mem_be", mem_be, 4'hF);
        check_eq("t1_stall_if_busy", stall_if, 1);
        check_eq("t1_if_rvalid_early", if_rvalid, 0);
        step;
        mem_ack = 1'b0; mem_rdata = '0;
        sample;
        check_eq("t1_if_rvalid", if_rvalid, 1);
        check_eq("t1_if_rdata", if_rdata, 32'h0050_0093);
        check_eq("t1_stall_if_done", stall_if, 0);
        check_eq("t1_mem_req_drop", mem_req, 0);
        step;
        sample;
        check_eq("t1_if_rvalid_pulse", if_rvalid, 0);

        // Store with three wait cycles
        step;
        dm_req = 1'b1; dm_we = 1'b1; dm_addr = 32'h2000; dm_wdata = 32'hDEAD_BEEF; dm_be = 4'hF;
        sample;
        check_eq("t2_dm_gnt", dm_gnt, 1);
        check_eq("t2_if_gnt", if_gnt, 0);
        step;
        dm_req = 1'b0; dm_we = 1'b0; dm_addr = '0; dm_wdata = '0; dm_be = '0;
        for (int w = 0; w < 4; w++) begin
            if (w == 3) begin
                mem_ack = 1'b1; mem_rdata = 32'h1234_5678;
            end
            sample;
            check_eq("t2_hold_req", mem_req, 1);
            check_eq("t2_hold_we", mem_we, 1);
            check_eq("t2_hold_addr", mem_addr, 32'h2000);
            check_eq("t2_hold_wdata", mem_wdata, 32'hDEAD_BEEF);
            check_eq("t2_hold_be", mem_be, 4'hF);
            check_eq("t2_stall_mem", stall_mem, 1);
            check_eq("t2_no_rvalid", dm_rvalid, 0);
            step;
        end
        mem_ack = 1'b0; mem_rdata = '0;
        sample;
        check_eq("t2_dm_rvalid", dm_rvalid, 1);
        check_eq("t2_dm_rdata_zero", dm_rdata, 0);
        check_eq("t2_if_rdata_hold", if_rdata, 32'h0050_0093);
        check_eq("t2_stall_mem_done", stall_mem, 0);

        // Simultaneous requests
`ifdef ARB_RR_EN
        fdm = 1'b0;
`else
        fdm = 1'b1;
`endif
        step;
        if_req = 1'b1; if_addr = 32'h104;
        dm_req = 1'b1; dm_we = 1'b0; dm_addr = 32'h3000; dm_be = 4'hF;
        sample;
        check_eq("t3_dm_gnt_first", dm_gnt, fdm);
        check_eq("t3_if_gnt_first", if_gnt, !fdm);
        check_eq("t3_loser_stall", fdm ? stall_if : stall_mem, 1);
        step;
        if (fdm) dm_req = 1'b0; else if_req = 1'b0;
        mem_ack = 1'b1; mem_rdata = fdm ? 32'hCAFE_F00D : 32'h0000_0013;
        sample;
        check_eq("t3_loser_wait_gnt", fdm ? if_gnt : dm_gnt, 0);
        check_eq("t3_loser_wait_stall", fdm ? stall_if : stall_mem, 1);
        check_eq("t3_winner_stall", fdm ? stall_mem : stall_if, 1);
        check_eq("t3_winner_addr", mem_addr, fdm ? 32'h3000 : 32'h104);
        step;
        mem_ack = 1'b0; mem_rdata = '0;
        sample;
        check_eq("t3_winner_rvalid", fdm ? dm_rvalid : if_rvalid, 1);
        check_eq("t3_winner_rdata", fdm ? dm_rdata : if_rdata, fdm ? 32'hCAFE_F00D : 32'h0000_0013);
        check_eq("t3_loser_gnt", fdm ? if_gnt : dm_gnt, 1);
        step;
        if (fdm) if_req = 1'b0; else dm_req = 1'b0;
        mem_ack = 1'b1; mem_rdata = fdm ? 32'h0000_0013 : 32'hCAFE_F00D;
        sample;
        check_eq("t3_loser_addr", mem_addr, fdm ? 32'h104 : 32'h3000);
        check_eq("t3_loser_busy_stall", fdm ? stall_if : stall_mem, 1);
        step;
        mem_ack = 1'b0; mem_rdata = '0;
        sample;
        check_eq("t3_loser_rvalid", fdm ? if_rvalid : dm_rvalid, 1);
        check_eq("t3_loser_rdata", fdm ? if_rdata : dm_rdata, fdm ? 32'h0000_0013 : 32'hCAFE_F00D);
        check_eq("t3_loser_stall_done", fdm ? stall_if : stall_mem, 0);

        // Both requests held continuously for four grants
        step;
        if_req = 1'b1; if_addr = 32'h108;
        dm_req = 1'b1; dm_we = 1'b0; dm_addr = 32'h3004; dm_be = 4'hF;
        for (int g = 0; g < 4; g++) begin
`ifdef ARB_RR_EN
            exp_dm = (g % 2) == 1;
`else
            exp_dm = 1'b1;
`endif
            sample;
            check_eq("t4_dm_gnt", dm_gnt, exp_dm);
            check_eq("t4_if_gnt", if_gnt, !exp_dm);
            step;
            mem_ack = 1'b1; mem_rdata = 32'h0000_1000 + g;
            sample;
            check_eq("t4_busy_no_gnt", {if_gnt, dm_gnt}, 2'b00);
            step;
            mem_ack = 1'b0; mem_rdata = '0;
        end
        if_req = 1'b0; dm_req = 1'b0; dm_addr = '0; if_addr = '0;

        // Reset while a load is pending
        step;
        dm_req = 1'b1; dm_we = 1'b0; dm_addr = 32'h4000; dm_be = 4'hF;
        sample;
        check_eq("t5_dm_gnt", dm_gnt, 1);
        step;
        dm_req = 1'b0; dm_addr = '0;
        #2;
        check_eq("t5_busy_before_rst", mem_req, 1);
        rst_n = 1'b0;
        #1;
        check_eq("t5_mem_req_async", mem_req, 0);
        check_eq("t5_stall_mem_async", stall_mem, 0);
        mem_ack = 1'b1; mem_rdata = 32'h5555_AAAA;
        step;
        check_eq("t5_no_rvalid_in_rst", dm_rvalid, 0);
        sample;
        rst_n = 1'b1;
        mem_ack = 1'b0; mem_rdata = '0;
        step;
        sample;
        check_eq("t5_no_rvalid_after", dm_rvalid, 0);
        check_eq("t5_dm_rdata_reset", dm_rdata, 0);
        check_eq("t5_if_rdata_reset", if_rdata, 0);
        step;
        if_req = 1'b1; if_addr = 32'h200;
        sample;
        check_eq("t5_if_gnt_after", if_gnt, 1);
        step;
        if_req = 1'b0; if_addr = '0; mem_ack = 1'b1; mem_rdata = 32'h0000_ABCD;
        sample;
        check_eq("t5_if_addr", mem_addr, 32'h200);
        step;
        mem_ack = 1'b0; mem_rdata = '0;
        sample;
        check_eq("t5_if_rvalid", if_rvalid, 1);
        check_eq("t5_if_rdata", if_rdata, 32'h0000_ABCD);

        // mem_ack while idle is ignored
        step;
        mem_ack = 1'b1; mem_rdata = 32'hFFFF_FFFF;
        sample;
        check_eq("t6_mem_req_idle", mem_req, 0);
        check_eq("t6_stall_if_idle", stall_if, 0);
        step;
        mem_ack = 1'b0; mem_rdata = '0;
        sample;
        check_eq("t6_if_rvalid", if_rvalid, 0);
        check_eq("t6_dm_rvalid", dm_rvalid, 0);
        check_eq("t6_if_rdata_hold", if_rdata, 32'h0000_ABCD);
        check_eq("t6_stall_mem_idle", stall_mem, 0);
        step;
        if_req = 1'b1; if_addr = 32'h300;
        sample;
        check_eq("t6_if_gnt", if_gnt, 1);
        step;
        if_req = 1'b0; if_addr = '0; mem_ack = 1'b1; mem_rdata = 32'h0000_0001;
        sample;
        check_eq("t6_mem_addr", mem_addr, 32'h300);
        step;
        mem_ack = 1'b0; mem_rdata = '0;
        sample;
        check_eq("t6_if_rdata", if_rdata, 32'h0000_0001);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
